// File: rtl/mdu_sequencer_if.sv
// rtl/mdu_sequencer_if.sv - request/result bundle between the EX stage and the multiply/divide sequencer
// Optional divzero signal is present when MDU_DIV0_FLAG_EN is defined.
interface mdu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             flush;
    logic             we_hi;
    logic             we_lo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
`ifdef MDU_DIV0_FLAG_EN
    logic             divzero;
`endif

    modport master (
        output start, op, srca, srcb, flush, we_hi, we_lo, wdata,
`ifdef MDU_DIV0_FLAG_EN
        input  divzero,
`endif
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, srca, srcb, flush, we_hi, we_lo, wdata,
`ifdef MDU_DIV0_FLAG_EN
        output divzero,
`endif
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - radix-2 multiply/restoring-divide sequencer owning HI/LO
// Define MDU_DIV0_FLAG_EN to add the divzero completion flag.
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    mdu_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] upper;
    logic [WIDTH-1:0] lower;
    logic             is_div;
    logic             neg_p;
    logic             neg_r;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             accept;
    logic             last_iter;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    assign accept    = bus.start && !bus.flush && (state == IDLE || state == DONE);
    assign last_iter = (count == CW'(WIDTH - 1));

    // Signed ops (op[0]==0) work on magnitudes; the most negative value maps to 2^(WIDTH-1).
    assign sign_a = !bus.op[0] && bus.srca[WIDTH-1];
    assign sign_b = !bus.op[0] && bus.srcb[WIDTH-1];
    assign mag_a  = sign_a ? -bus.srca : bus.srca;
    assign mag_b  = sign_b ? -bus.srcb : bus.srcb;

    assign mul_sum   = {1'b0, upper} + (lower[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign div_shift = {upper, lower[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ok    = !div_diff[WIDTH];

    assign prod     = {upper, lower};
    assign prod_fix = neg_p ? -prod : prod;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN: begin
                if (bus.flush)      state_nxt = IDLE;
                else if (last_iter) state_nxt = FIX;
            end
            FIX:  state_nxt = bus.flush ? IDLE : DONE;
            DONE: state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            RUN, FIX: bus.busy = 1'b1;
            DONE:     bus.done = 1'b1;
            default: ;
        endcase
    end

    // Multiplier lives in lower and shifts out LSB-first; dividend shifts out MSB-first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            opnd   <= '0;
            upper  <= '0;
            lower  <= '0;
            is_div <= 1'b0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (accept) begin
            count  <= '0;
            is_div <= bus.op[1];
            opnd   <= bus.op[1] ? mag_b : mag_a;
            lower  <= bus.op[1] ? mag_a : mag_b;
            upper  <= '0;
            neg_p  <= (sign_a ^ sign_b) && !(bus.op[1] && bus.srcb == '0);
            neg_r  <= bus.op[1] ? sign_a : (sign_a ^ sign_b);
        end else if (state == RUN) begin
            count <= count + CW'(1);
            if (is_div) begin
                upper <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                lower <= {lower[WIDTH-2:0], div_ok};
            end else begin
                upper <= mul_sum[WIDTH:1];
                lower <= {mul_sum[0], lower[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == FIX) begin
            if (!bus.flush) begin
                if (is_div) begin
                    lo_q <= neg_p ? -lower : lower;
                    hi_q <= neg_r ? -upper : upper;
                end else begin
                    hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                    lo_q <= prod_fix[WIDTH-1:0];
                end
            end
        end else if (state == IDLE || state == DONE) begin
            if (bus.we_hi) hi_q <= bus.wdata;
            if (bus.we_lo) lo_q <= bus.wdata;
        end
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;

`ifdef MDU_DIV0_FLAG_EN
    logic b_zero;
    logic dz_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_zero <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            if (accept) b_zero <= (bus.srcb == '0);
            dz_q <= (state == FIX) && !bus.flush && is_div && b_zero;
        end
    end

    assign bus.divzero = dz_q;
`endif
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - scoreboard bench for mdu_sequencer
// Checks divzero as well when MDU_DIV0_FLAG_EN is defined.
module tb_mdu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;

    mdu_sequencer_if #(.WIDTH(32)) bus ();

    mdu_sequencer #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        longint      sa, sbv, q, r;
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        case (op)
            2'b00: begin
                sa = $signed(a); sbv = $signed(b);
                p = sa * sbv;
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1;
                end else if (op == 2'b11) begin
                    e.lo = a / b; e.hi = a % b;
                end else begin
                    sa = $signed(a); sbv = $signed(b);
                    q = sa / sbv; r = sa % sbv;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Caller sits 1 time unit after a rising edge; returns 1 time unit after the accept edge.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        bus.start = 1'b1; bus.op = op; bus.srca = a; bus.srcb = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (push) sb.push_back(model(op, a, b));
    endtask

    task automatic wait_done(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            n++;
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2;
        vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        vectors++; if (bus.lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
`ifdef MDU_DIV0_FLAG_EN
        vectors++; if (bus.divzero !== 1'b0) begin miscompares++; $display("FAIL reset_divzero got %b want 0", bus.divzero); end
`endif
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        exp_hi = '0; exp_lo = '0;
    endtask

    task automatic test_multu_timing;
        exp_t e;
        bit   bad = 1'b0;
        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        vectors++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin miscompares++; $display("FAIL timing_accept busy=%b done=%b want 1/0", bus.busy, bus.done); end
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad = 1'b1;
        end
        vectors++; if (bad) begin miscompares++; $display("FAIL timing_run busy/done wrong within edges N+1..N+32"); end
        @(posedge clk); #1;
        vectors++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL timing_done done=%b busy=%b want 1/0", bus.done, bus.busy); end
        e = sb.pop_front();
        vectors++; if (bus.hi !== e.hi) begin miscompares++; $display("FAIL multu_max_hi got %h want %h", bus.hi, e.hi); end
        vectors++; if (bus.lo !== e.lo) begin miscompares++; $display("FAIL multu_max_lo got %h want %h", bus.lo, e.lo); end
        vectors++; if (e.hi !== 32'hFFFF_FFFE || e.lo !== 32'h0000_0001) begin miscompares++; $display("FAIL multu_model got %h_%h want fffffffe_00000001", e.hi, e.lo); end
        exp_hi = e.hi; exp_lo = e.lo;
        @(posedge clk); #1;
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL timing_done_width got %b want 0", bus.done); end
    endtask

    task automatic test_signed;
        logic [1:0]  ops [6] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b11};
        logic [31:0] as  [6] = '{-32'sd3, -32'sd7, 32'h8000_0000, 32'h8000_0000, 32'd7, 32'd1000};
        logic [31:0] bs  [6] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -32'sd2, 32'd7};
        exp_t e;
        bit   ok;
        int   n;
        for (int i = 0; i < 6; i++) begin
            launch(ops[i], as[i], bs[i], 1'b1);
            wait_done(ok, n);
            vectors++; if (!ok) begin miscompares++; $display("FAIL signed_%0d_timeout no done", i); end
            e = sb.pop_front();
            vectors++; if (bus.hi !== e.hi) begin miscompares++; $display("FAIL signed_%0d_hi got %h want %h", i, bus.hi, e.hi); end
            vectors++; if (bus.lo !== e.lo) begin miscompares++; $display("FAIL signed_%0d_lo got %h want %h", i, bus.lo, e.lo); end
`ifdef MDU_DIV0_FLAG_EN
            vectors++; if (bus.divzero !== 1'b0) begin miscompares++; $display("FAIL signed_%0d_divzero got %b want 0", i, bus.divzero); end
`endif
            exp_hi = e.hi; exp_lo = e.lo;
        end
    endtask

    task automatic test_div0;
        logic [1:0]  ops [2] = '{2'b11, 2'b10};
        logic [31:0] as  [2] = '{32'd100, -32'sd5};
        exp_t e;
        bit   ok;
        int   n;
        for (int i = 0; i < 2; i++) begin
            launch(ops[i], as[i], 32'd0, 1'b1);
            wait_done(ok, n);
            vectors++; if (!ok || n != 33) begin miscompares++; $display("FAIL div0_%0d_latency got %0d want 33", i, n); end
            e = sb.pop_front();
            vectors++; if (bus.lo !== e.lo) begin miscompares++; $display("FAIL div0_%0d_lo got %h want %h", i, bus.lo, e.lo); end
            vectors++; if (bus.hi !== e.hi) begin miscompares++; $display("FAIL div0_%0d_hi got %h want %h", i, bus.hi, e.hi); end
`ifdef MDU_DIV0_FLAG_EN
            vectors++; if (bus.divzero !== 1'b1) begin miscompares++; $display("FAIL div0_%0d_flag got %b want 1", i, bus.divzero); end
            @(posedge clk); #1;
            vectors++; if (bus.divzero !== 1'b0) begin miscompares++; $display("FAIL div0_%0d_flag_clear got %b want 0", i, bus.divzero); end
`endif
            exp_hi = e.hi; exp_lo = e.lo;
        end
    endtask

    task automatic test_flush;
        bit seen = 1'b0;
        launch(2'b01, 32'd5, 32'd5, 1'b0);
        repeat (9) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL flush_idle busy=%b done=%b want 0/0", bus.busy, bus.done); end
        repeat (40) begin @(posedge clk); #1; if (bus.done === 1'b1) seen = 1'b1; end
        vectors++; if (seen) begin miscompares++; $display("FAIL flush_no_done got done pulse want none"); end
        vectors++; if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin miscompares++; $display("FAIL flush_keep got %h_%h want %h_%h", bus.hi, bus.lo, exp_hi, exp_lo); end
        // flush wins over a simultaneous start
        bus.flush = 1'b1;
        launch(2'b01, 32'd3, 32'd3, 1'b0);
        bus.flush = 1'b0;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL flush_over_start busy got %b want 0", bus.busy); end
    endtask

    task automatic test_ignored_start;
        exp_t e;
        bit   ok;
        bit   seen = 1'b0;
        int   n;
        launch(2'b01, 32'd6, 32'd7, 1'b1);
        repeat (4) begin @(posedge clk); #1; end
        launch(2'b01, 32'd9, 32'd9, 1'b0);
        wait_done(ok, n);
        vectors++; if (!ok || n != 28) begin miscompares++; $display("FAIL ignored_start_latency got %0d want 28", n); end
        e = sb.pop_front();
        vectors++; if (bus.lo !== e.lo || bus.hi !== e.hi) begin miscompares++; $display("FAIL ignored_start_result got %h_%h want %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
        exp_hi = e.hi; exp_lo = e.lo;
        repeat (40) begin @(posedge clk); #1; if (bus.done === 1'b1) seen = 1'b1; end
        vectors++; if (seen) begin miscompares++; $display("FAIL ignored_start_extra_done got a second done"); end
    endtask

    task automatic test_mtlo;
        exp_t e;
        bit   ok;
        int   n;
        bus.we_lo = 1'b1; bus.wdata = 32'h0000_1234;
        @(posedge clk); #1;
        bus.we_lo = 1'b0;
        exp_lo = 32'h0000_1234;
        vectors++; if (bus.lo !== exp_lo || bus.hi !== exp_hi) begin miscompares++; $display("FAIL mtlo_idle got %h_%h want %h_%h", bus.hi, bus.lo, exp_hi, exp_lo); end
        bus.we_hi = 1'b1; bus.we_lo = 1'b1; bus.wdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        bus.we_hi = 1'b0; bus.we_lo = 1'b0;
        exp_hi = 32'hCAFE_0001; exp_lo = 32'hCAFE_0001;
        vectors++; if (bus.lo !== exp_lo || bus.hi !== exp_hi) begin miscompares++; $display("FAIL mthi_mtlo_both got %h_%h want %h_%h", bus.hi, bus.lo, exp_hi, exp_lo); end
        launch(2'b01, 32'd2, 32'd3, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        bus.we_lo = 1'b1; bus.we_hi = 1'b1; bus.wdata = 32'h0000_DEAD;
        @(posedge clk); #1;
        bus.we_lo = 1'b0; bus.we_hi = 1'b0;
        vectors++; if (bus.lo !== exp_lo || bus.hi !== exp_hi) begin miscompares++; $display("FAIL mtlo_run_dropped got %h_%h want %h_%h", bus.hi, bus.lo, exp_hi, exp_lo); end
        wait_done(ok, n);
        e = sb.pop_front();
        vectors++; if (!ok || bus.lo !== e.lo || bus.hi !== e.hi) begin miscompares++; $display("FAIL mtlo_run_result got %h_%h want %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
        exp_hi = e.hi; exp_lo = e.lo;
    endtask

    task automatic test_async_reset;
        launch(2'b01, 32'd123, 32'd456, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        #2;
        rst = 1'b0;
        #1;
        vectors++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin miscompares++; $display("FAIL async_rst_hilo got %h_%h want 0_0", bus.hi, bus.lo); end
        vectors++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin miscompares++; $display("FAIL async_rst_ctl busy=%b done=%b want 0/0", bus.busy, bus.done); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        exp_hi = '0; exp_lo = '0;
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL async_rst_resume busy got %b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        bit   ok;
        int   n;
        launch(2'b00, -32'sd3, 32'd7, 1'b1);
        wait_done(ok, n);
        e = sb.pop_front();
        vectors++; if (!ok || bus.hi !== e.hi || bus.lo !== e.lo) begin miscompares++; $display("FAIL b2b_first got %h_%h want %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
        launch(2'b11, 32'd1000, 32'd7, 1'b1);
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept_in_done busy got %b want 1", bus.busy); end
        wait_done(ok, n);
        e = sb.pop_front();
        vectors++; if (!ok || n != 33) begin miscompares++; $display("FAIL b2b_latency got %0d want 33", n); end
        vectors++; if (bus.hi !== e.hi || bus.lo !== e.lo) begin miscompares++; $display("FAIL b2b_second got %h_%h want %h_%h", bus.hi, bus.lo, e.hi, e.lo); end
        exp_hi = e.hi; exp_lo = e.lo;
    endtask

    task automatic test_random;
        exp_t        e;
        bit          ok;
        int          n;
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 4 == 3) ? 32'd0 : ((i % 4 == 2) ? 32'($urandom_range(1, 100)) : $urandom);
            launch(op, a, b, 1'b1);
            wait_done(ok, n);
            e = sb.pop_front();
            vectors++; if (!ok || bus.hi !== e.hi || bus.lo !== e.lo) begin miscompares++; $display("FAIL random_%0d op=%0d a=%h b=%h got %h_%h want %h_%h", i, op, a, b, bus.hi, bus.lo, e.hi, e.lo); end
`ifdef MDU_DIV0_FLAG_EN
            vectors++; if (bus.divzero !== e.dz) begin miscompares++; $display("FAIL random_%0d_divzero got %b want %b", i, bus.divzero, e.dz); end
`endif
            exp_hi = e.hi; exp_lo = e.lo;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.srca = '0; bus.srcb = '0;
        bus.flush = 1'b0; bus.we_hi = 1'b0; bus.we_lo = 1'b0; bus.wdata = '0;
        test_reset();
        test_multu_timing();
        test_signed();
        test_div0();
        test_flush();
        test_ignored_start();
        test_mtlo();
        test_async_reset();
        test_back_to_back();
        test_random();
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL scoreboard_drain left %0d want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
